multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multicycle MIPS-subset control unit: a Moore FSM that sequences fetch/decode/execute/mem/writeback.
//  Drives datapath muxes and enables for PC, IR, register file, ALU and unified memory.
//  Adds a variable-latency memory handshake (mem_ready), illegal-opcode trap, instruction-retire pulse and state visibility.
//  Sits between IR[31:26] and the multicycle datapath; one instance per CPU.
// PARAMETERS
//  OPCODE_W   6          opcode field width
//  MEM_WAIT   1          1: memory states hold until mem_ready; 0: mem_ready ignored (single-cycle memory)
//  OP_RTYPE   6'b000000  R-type opcode
//  OP_LW      6'b100011  load word
//  OP_SW      6'b101011  store word
//  OP_BEQ     6'b000100  branch if equal
//  OP_ADDI    6'b001000  add immediate
//  OP_J       6'b000010  jump
// PORTS
//  clock          in   1         rising-edge clock
//  reset          in   1         synchronous, active-high
//  opcode         in   OPCODE_W  IR[31:26], valid from DECODE onward
//  mem_ready      in   1         memory completes the current read/write this cycle
//  pc_write_cond  out  1         PC write if ALU zero (BEQ)
//  pc_write       out  1         unconditional PC write
//  iord           out  1         0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read       out  1         memory read request
//  mem_write      out  1         memory write request
//  mem_to_reg     out  1         1: writeback from MDR
//  ir_write       out  1         latch IR
//  alu_src_a      out  1         0: PC, 1: A reg
//  reg_write      out  1         register-file write enable
//  reg_dst        out  1         1: rd, 0: rt
//  pc_src         out  2         00 ALU, 01 ALUOut, 10 jump target
//  alu_op         out  2         00 add, 01 sub, 10 funct-decoded
//  alu_src_b      out  2         00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  illegal_op     out  1         sticky: unknown opcode decoded
//  instr_done     out  1         one-cycle pulse on instruction retire
//  state_o        out  4         current state (debug)
// BEHAVIOUR
//  State register 4 bits; reset (sync) -> FETCH; while reset=1 every output is 0; illegal_op cleared only by reset.
//  Outputs decoded combinationally from state (and mem_ready in mem states); no unlisted output may float/latch: default 0.
//  FETCH(0): mem_read=1,iord=0,alu_src_a=0,alu_src_b=01,alu_op=00,pc_src=00; ir_write=pc_write=1 only when mem_ready|!MEM_WAIT; then DECODE, else hold.
//  DECODE(1): alu_src_a=0,alu_src_b=11,alu_op=00. Next: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDI_EX, J->JUMP, other->TRAP.
//  MEMADR(2): alu_src_a=1,alu_src_b=10,alu_op=00 -> LW:MEMRD, SW:MEMWR.
//  MEMRD(3): mem_read=1,iord=1; advance to MEMWB on mem_ready (or immediately if !MEM_WAIT).
//  MEMWB(4): reg_write=1,mem_to_reg=1,reg_dst=0,instr_done=1 -> FETCH.
//  MEMWR(5): mem_write=1,iord=1; on completion instr_done=1 -> FETCH, else hold with mem_write held high.
//  EXEC(6): alu_src_a=1,alu_src_b=00,alu_op=10 -> RTWB(7): reg_write=1,reg_dst=1,mem_to_reg=0,instr_done=1 -> FETCH.
//  BRANCH(8): alu_src_a=1,alu_src_b=00,alu_op=01,pc_write_cond=1,pc_src=01,instr_done=1 -> FETCH.
//  ADDI_EX(9): alu_src_a=1,alu_src_b=10,alu_op=00 -> ADDI_WB(10): reg_write=1,reg_dst=0,mem_to_reg=0,instr_done=1 -> FETCH.
//  JUMP(11): pc_write=1,pc_src=10,instr_done=1 -> FETCH.
//  TRAP(12): illegal_op=1, all enables 0, self-loop until reset. States 13-15 unreachable; if entered -> FETCH next cycle.
//  Latency (MEM_WAIT=0): R/ADDI 4, LW 5, SW 4, BEQ/J 3 cycles; each wait cycle with mem_ready=0 adds 1.
//  mem_ready outside FETCH/MEMRD/MEMWR ignored. Reset mid-wait abandons access: mem_read/mem_write drop same cycle.
//  opcode sampled only in DECODE; changes elsewhere have no effect.
// STRUCTURE
//  Shared package/header: state encodings (S_FETCH..S_TRAP), opcode constants, alu_op/alu_src_b/pc_src encodings, shared with datapath and ALU control.
//  No sub-module; ALU funct decode lives in the separate ALU control block, not here.
// TESTING
//  MEM_WAIT=0, R-type opcode 0 after reset -> states 0,1,6,7,0; reg_write=1,reg_dst=1 only in state 7; instr_done once.
//  MEM_WAIT=1, LW, mem_ready low 3 cycles in FETCH and 2 in MEMRD -> ir_write only on ready cycle; 10 cycles total; mem_to_reg=1 in MEMWB.
//  SW with mem_ready low 1 cycle -> mem_write high 2 consecutive cycles, iord=1, then FETCH; reg_write never 1.
//  BEQ then J -> BRANCH asserts pc_write_cond=1,pc_src=01,alu_op=01; JUMP asserts pc_write=1,pc_src=10; each 3 cycles.
//  Opcode 6'b111111 -> TRAP, illegal_op=1 held 20 cycles with all enables 0; reset=1 one cycle -> illegal_op=0, state_o=0.
//  Reset asserted during MEMRD wait -> next cycle state_o=0, all outputs 0 while reset high; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: state, opcode and datapath-select encodings shared with datapath and ALU control
package multicycle_ctrl_fsm_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SL2  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: opcode/memory handshake in, datapath controls out; master is the control FSM
interface multicycle_ctrl_fsm_if #(parameter int OPCODE_W = 6);
  logic [OPCODE_W-1:0] opcode;
  logic mem_ready;
  logic pc_write_cond, pc_write, iord, mem_read, mem_write, mem_to_reg;
  logic ir_write, alu_src_a, reg_write, reg_dst;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic illegal_op, instr_done;
  logic [3:0] state_o;
  modport master (
    input opcode, mem_ready,
    output pc_write_cond, pc_write, iord, mem_read, mem_write, mem_to_reg,
    output ir_write, alu_src_a, reg_write, reg_dst, pc_src, alu_op, alu_src_b,
    output illegal_op, instr_done, state_o
  );
  modport slave (
    output opcode, mem_ready,
    input pc_write_cond, pc_write, iord, mem_read, mem_write, mem_to_reg,
    input ir_write, alu_src_a, reg_write, reg_dst, pc_src, alu_op, alu_src_b,
    input illegal_op, instr_done, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM sequencing a multicycle MIPS-subset datapath with memory wait states
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int                  OPCODE_W = 6,
  parameter bit                  MEM_WAIT = 1'b1,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(OPC_RTYPE),
  parameter logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(OPC_LW),
  parameter logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(OPC_SW),
  parameter logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(OPC_BEQ),
  parameter logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(OPC_ADDI),
  parameter logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(OPC_J)
) (
  input logic clock,
  input logic reset,
  multicycle_ctrl_fsm_if.master bus
);
  state_t state;
  logic is_load;
  logic done;
  assign done = bus.mem_ready | ~MEM_WAIT;
  // is_load captures the opcode in DECODE so later opcode changes cannot redirect MEMADR
  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else case (state)
      S_FETCH:   state <= done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_load <= bus.opcode == OP_LW;
        state <= (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                 bus.opcode == OP_RTYPE ? S_EXEC :
                 bus.opcode == OP_BEQ   ? S_BRANCH :
                 bus.opcode == OP_ADDI  ? S_ADDI_EX :
                 bus.opcode == OP_J     ? S_JUMP : S_TRAP;
      end
      S_MEMADR:  state <= is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state <= done ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state <= done ? S_FETCH : S_MEMWR;
      S_EXEC:    state <= S_RTWB;
      S_ADDI_EX: state <= S_ADDI_WB;
      S_TRAP:    state <= S_TRAP;
      default:   state <= S_FETCH;
    endcase
  end
  always_comb begin
    bus.pc_write_cond = 1'b0;
    bus.pc_write = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.ir_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 1'b0;
    bus.pc_src = PC_ALU;
    bus.alu_op = ALU_ADD;
    bus.alu_src_b = SRCB_B;
    bus.illegal_op = 1'b0;
    bus.instr_done = 1'b0;
    bus.state_o = reset ? 4'd0 : state;
    if (!reset) case (state)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src_b = SRCB_4;
        bus.ir_write = done;
        bus.pc_write = done;
      end
      S_DECODE: bus.alu_src_b = SRCB_SL2;
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord = 1'b1;
        bus.instr_done = done;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = ALU_FUNCT;
      end
      S_RTWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src = PC_ALUOUT;
        bus.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src = PC_JUMP;
        bus.instr_done = 1'b1;
      end
      S_TRAP: bus.illegal_op = 1'b1;
      default: ;
    endcase
  end
endmodule
